// File: rtl/car_sched_pkg.sv
// car_sched_pkg: shared state encoding, car count and coordinate widths for the frame scheduler
package car_sched_pkg;
    localparam int NUM_CARS = 2;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int DIR_W = 3;
    localparam int COLOUR_W = 9;
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LATCH      = 3'd1,
        S_ERASE_REQ  = 3'd2,
        S_ERASE_WAIT = 3'd3,
        S_DRAW_REQ   = 3'd4,
        S_DRAW_WAIT  = 3'd5,
        S_DONE       = 3'd6
    } state_t;
endpackage

// File: rtl/car_sched_watchdog.sv
// car_sched_watchdog: per-request cycle counter that flags expiry after TIMEOUT waiting cycles
module car_sched_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic iClock,
    input  logic iResetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_count;
    always_ff @(posedge iClock) begin
        if (!iResetn || i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + 1'b1;
    end
    assign o_expire = i_enable && (r_count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/car_frame_scheduler.sv
// car_frame_scheduler: per-frame erase-then-draw sequencer for two cars with VGA stream mux
module car_frame_scheduler
    import car_sched_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iEnable,
    input  logic                iFrameTick,
    input  logic [X_W-1:0]      iX0,
    input  logic [X_W-1:0]      iX1,
    input  logic [Y_W-1:0]      iY0,
    input  logic [Y_W-1:0]      iY1,
    input  logic [DIR_W-1:0]    iDir0,
    input  logic [DIR_W-1:0]    iDir1,
    output logic [X_W-1:0]      oRX,
    output logic [Y_W-1:0]      oRY,
    output logic [DIR_W-1:0]    oRdir,
    output logic                oEraseCar,
    input  logic                iEraseCarDone,
    output logic                oDrawCar,
    input  logic                iDrawCarDone,
    input  logic [X_W-1:0]      iEraseX,
    input  logic [X_W-1:0]      iDrawX,
    input  logic [Y_W-1:0]      iEraseY,
    input  logic [Y_W-1:0]      iDrawY,
    input  logic [COLOUR_W-1:0] iEraseColour,
    input  logic [COLOUR_W-1:0] iDrawColour,
    input  logic                iErasePlot,
    input  logic                iDrawPlot,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oFrameDone,
    output logic                oOverrun,
    output logic                oTimeout
);
    state_t r_state, w_next;
    logic r_idx, r_old_valid, r_overrun, r_timeout;
    logic [X_W-1:0]   r_old_x [NUM_CARS];
    logic [X_W-1:0]   r_new_x [NUM_CARS];
    logic [Y_W-1:0]   r_old_y [NUM_CARS];
    logic [Y_W-1:0]   r_new_y [NUM_CARS];
    logic [DIR_W-1:0] r_old_d [NUM_CARS];
    logic [DIR_W-1:0] r_new_d [NUM_CARS];
    logic w_erase, w_draw, w_req, w_wait, w_done, w_expire, w_advance;

    assign w_erase   = (r_state == S_ERASE_REQ) || (r_state == S_ERASE_WAIT);
    assign w_draw    = (r_state == S_DRAW_REQ) || (r_state == S_DRAW_WAIT);
    assign w_req     = (r_state == S_ERASE_REQ) || (r_state == S_DRAW_REQ);
    assign w_wait    = (r_state == S_ERASE_WAIT) || (r_state == S_DRAW_WAIT);
    assign w_done    = (r_state == S_ERASE_WAIT && iEraseCarDone) || (r_state == S_DRAW_WAIT && iDrawCarDone);
    assign w_advance = w_done || w_expire;

    car_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .iClock   (iClock),
        .iResetn  (iResetn),
        .i_clear  (w_req),
        .i_enable (w_wait),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = (iFrameTick && iEnable) ? S_LATCH : S_IDLE;
            S_LATCH:      w_next = r_old_valid ? S_ERASE_REQ : S_DRAW_REQ;
            S_ERASE_REQ:  w_next = S_ERASE_WAIT;
            S_ERASE_WAIT: w_next = w_advance ? (r_idx ? S_DRAW_REQ : S_ERASE_REQ) : S_ERASE_WAIT;
            S_DRAW_REQ:   w_next = S_DRAW_WAIT;
            S_DRAW_WAIT:  w_next = w_advance ? (r_idx ? S_DONE : S_DRAW_REQ) : S_DRAW_WAIT;
            default:      w_next = S_IDLE;
        endcase
    end

    // strobes are gated by reset so they fall in the cycle reset asserts
    assign oEraseCar  = iResetn && (r_state == S_ERASE_REQ);
    assign oDrawCar   = iResetn && (r_state == S_DRAW_REQ);
    assign oFrameDone = iResetn && (r_state == S_DONE);

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state     <= S_IDLE;
            r_idx       <= 1'b0;
            r_old_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_old_x     <= '{default: '0};
            r_new_x     <= '{default: '0};
            r_old_y     <= '{default: '0};
            r_new_y     <= '{default: '0};
            r_old_d     <= '{default: '0};
            r_new_d     <= '{default: '0};
        end else begin
            r_state <= w_next;
            if (iFrameTick && r_state != S_IDLE) r_overrun <= 1'b1;
            if (w_expire && !w_done) r_timeout <= 1'b1;
            if (w_wait && w_advance) r_idx <= ~r_idx;
            if (r_state == S_LATCH) begin
                r_idx      <= 1'b0;
                r_new_x[0] <= iX0;
                r_new_x[1] <= iX1;
                r_new_y[0] <= iY0;
                r_new_y[1] <= iY1;
                r_new_d[0] <= iDir0;
                r_new_d[1] <= iDir1;
            end
            if (r_state == S_DONE) begin
                r_old_x     <= r_new_x;
                r_old_y     <= r_new_y;
                r_old_d     <= r_new_d;
                r_old_valid <= 1'b1;
            end
        end
    end

    assign oRX     = w_erase ? r_old_x[r_idx] : w_draw ? r_new_x[r_idx] : r_new_x[0];
    assign oRY     = w_erase ? r_old_y[r_idx] : w_draw ? r_new_y[r_idx] : r_new_y[0];
    assign oRdir   = w_erase ? r_old_d[r_idx] : w_draw ? r_new_d[r_idx] : r_new_d[0];
    assign oX      = w_draw ? iDrawX : iEraseX;
    assign oY      = w_draw ? iDrawY : iEraseY;
    assign oColour = w_draw ? iDrawColour : iEraseColour;
    assign oPlot   = w_erase ? iErasePlot : w_draw ? iDrawPlot : 1'b0;
    assign oBusy    = (r_state != S_IDLE);
    assign oOverrun = r_overrun;
    assign oTimeout = r_timeout;
endmodule

// File: tb/tb_car_frame_scheduler.sv
// tb_car_frame_scheduler: scoreboard bench with engine responders and directed frame scenarios
module tb_car_frame_scheduler;
    logic iClock = 1'b0;
    always #5 iClock = ~iClock;

    logic iResetn, iEnable, iFrameTick;
    logic [7:0] iX0, iX1, iEraseX, iDrawX, oRX, oX;
    logic [6:0] iY0, iY1, iEraseY, iDrawY, oRY, oY;
    logic [2:0] iDir0, iDir1, oRdir;
    logic [8:0] iEraseColour, iDrawColour, oColour;
    logic iErasePlot, iDrawPlot, iEraseCarDone, iDrawCarDone;
    logic oEraseCar, oDrawCar, oPlot, oBusy, oFrameDone, oOverrun, oTimeout;

    car_frame_scheduler #(.TIMEOUT(15)) dut (
        .iClock(iClock), .iResetn(iResetn), .iEnable(iEnable), .iFrameTick(iFrameTick),
        .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1), .iDir0(iDir0), .iDir1(iDir1),
        .oRX(oRX), .oRY(oRY), .oRdir(oRdir),
        .oEraseCar(oEraseCar), .iEraseCarDone(iEraseCarDone),
        .oDrawCar(oDrawCar), .iDrawCarDone(iDrawCarDone),
        .iEraseX(iEraseX), .iDrawX(iDrawX), .iEraseY(iEraseY), .iDrawY(iDrawY),
        .iEraseColour(iEraseColour), .iDrawColour(iDrawColour),
        .iErasePlot(iErasePlot), .iDrawPlot(iDrawPlot),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
        .oBusy(oBusy), .oFrameDone(oFrameDone), .oOverrun(oOverrun), .oTimeout(oTimeout)
    );

    typedef struct packed {
        logic [1:0] k;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] d;
    } ev_t;

    ev_t sb[$];
    int errors = 0;
    int checks = 0;
    int frames = 0;
    bit mv = 1'b0;
    logic [7:0] mx [2];
    logic [6:0] my [2];
    logic [2:0] md [2];
    bit erase_hang = 1'b0;
    int ec = 0;
    int dc = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    initial begin
        iEraseCarDone = 1'b0;
        iDrawCarDone = 1'b0;
        forever begin
            @(negedge iClock);
            iEraseCarDone = 1'b0;
            iDrawCarDone = 1'b0;
            if (!iResetn) begin
                ec = 0;
                dc = 0;
            end else begin
                if (oEraseCar) ec = erase_hang ? 0 : 5;
                else if (ec > 0) begin
                    ec--;
                    if (ec == 0) iEraseCarDone = 1'b1;
                end
                if (oDrawCar) dc = 5;
                else if (dc > 0) begin
                    dc--;
                    if (dc == 0) iDrawCarDone = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [1:0] k;
        ev_t e;
        forever begin
            @(negedge iClock);
            if (iResetn === 1'b1) begin
                if (!oBusy) chk("idle_plot", oPlot, 0);
                if (oEraseCar || oDrawCar || oFrameDone) begin
                    k = oEraseCar ? 2'd1 : oDrawCar ? 2'd2 : 2'd3;
                    if (sb.size() == 0) chk("unexpected_event", k, 0);
                    else begin
                        e = sb.pop_front();
                        chk("event_kind", k, e.k);
                        if (k == 2'd3) frames++;
                        else begin
                            chk("req_x", oRX, e.x);
                            chk("req_y", oRY, e.y);
                            chk("req_dir", oRdir, e.d);
                            chk("vga_plot", oPlot, k == 2'd1 ? 32'd1 : 32'd0);
                            chk("vga_x", oX, k == 2'd1 ? 32'hA5 : 32'h3C);
                            chk("vga_y", oY, k == 2'd1 ? 32'h15 : 32'h2A);
                            chk("vga_colour", oColour, k == 2'd1 ? 32'h1A5 : 32'h0C3);
                        end
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] d0,
                               input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] d1);
        if (mv) begin
            sb.push_back(ev_t'({2'd1, mx[0], my[0], md[0]}));
            sb.push_back(ev_t'({2'd1, mx[1], my[1], md[1]}));
        end
        sb.push_back(ev_t'({2'd2, x0, y0, d0}));
        sb.push_back(ev_t'({2'd2, x1, y1, d1}));
        sb.push_back(ev_t'({2'd3, 8'd0, 7'd0, 3'd0}));
        iX0 = x0; iY0 = y0; iDir0 = d0;
        iX1 = x1; iY1 = y1; iDir1 = d1;
        @(negedge iClock);
        iFrameTick = 1'b1;
        @(negedge iClock);
        iFrameTick = 1'b0;
        chk("busy_in_latch", oBusy, 1);
        @(negedge iClock);
        chk(mv ? "erase_req_latency" : "draw_req_latency", mv ? oEraseCar : oDrawCar, 1);
        mx[0] = x0; my[0] = y0; md[0] = d0;
        mx[1] = x1; my[1] = y1; md[1] = d1;
        mv = 1'b1;
    endtask

    task automatic wait_frame(input int f0);
        for (int i = 0; i < 1000 && frames == f0; i++) @(negedge iClock);
        chk("frame_done_seen", frames != f0, 1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        iResetn = 1'b0; iEnable = 1'b1; iFrameTick = 1'b0;
        iX0 = '0; iX1 = '0; iY0 = '0; iY1 = '0; iDir0 = '0; iDir1 = '0;
        iEraseX = 8'hA5; iEraseY = 7'h15; iEraseColour = 9'h1A5; iErasePlot = 1'b1;
        iDrawX = 8'h3C; iDrawY = 7'h2A; iDrawColour = 9'h0C3; iDrawPlot = 1'b0;
        repeat (3) @(negedge iClock);
        chk("rst_busy", oBusy, 0);
        chk("rst_erase", oEraseCar, 0);
        chk("rst_draw", oDrawCar, 0);
        chk("rst_frame_done", oFrameDone, 0);
        chk("rst_overrun", oOverrun, 0);
        chk("rst_timeout", oTimeout, 0);
        chk("rst_plot", oPlot, 0);
        chk("rst_rx", oRX, 0);
        iResetn = 1'b1;
        @(negedge iClock);

        f0 = frames;
        start_frame(8'd10, 7'd20, 3'd2, 8'd50, 7'd60, 3'd0);
        wait_frame(f0);

        f0 = frames;
        start_frame(8'd11, 7'd20, 3'd2, 8'd50, 7'd61, 3'd0);
        wait_frame(f0);

        chk("overrun_clear_before", oOverrun, 0);
        f0 = frames;
        start_frame(8'd12, 7'd21, 3'd3, 8'd49, 7'd61, 3'd1);
        @(negedge iClock);
        iFrameTick = 1'b1;
        @(negedge iClock);
        iFrameTick = 1'b0;
        chk("overrun_set", oOverrun, 1);
        wait_frame(f0);
        repeat (40) @(negedge iClock);
        chk("single_frame_done", frames, f0 + 1);
        chk("overrun_sticky", oOverrun, 1);
        chk("idle_after_overrun", oBusy, 0);

        erase_hang = 1'b1;
        f0 = frames;
        start_frame(8'd13, 7'd22, 3'd4, 8'd48, 7'd62, 3'd5);
        repeat (15) @(negedge iClock);
        chk("timeout_not_early", oTimeout, 0);
        chk("no_early_erase", oEraseCar, 0);
        @(negedge iClock);
        chk("erase1_after_timeout", oEraseCar, 1);
        chk("timeout_set", oTimeout, 1);
        wait_frame(f0);
        erase_hang = 1'b0;
        chk("timeout_sticky", oTimeout, 1);

        f0 = frames;
        start_frame(8'd20, 7'd30, 3'd6, 8'd40, 7'd50, 3'd7);
        for (int i = 0; i < 500 && !oDrawCar; i++) @(negedge iClock);
        chk("reached_draw", oDrawCar, 1);
        @(negedge iClock);
        chk("in_draw_wait", oBusy, 1);
        iResetn = 1'b0;
        @(negedge iClock);
        chk("reset_busy", oBusy, 0);
        chk("reset_draw", oDrawCar, 0);
        chk("reset_frame_done", oFrameDone, 0);
        chk("reset_overrun", oOverrun, 0);
        chk("reset_timeout", oTimeout, 0);
        @(negedge iClock);
        iResetn = 1'b1;
        sb.delete();
        mv = 1'b0;
        @(negedge iClock);

        f0 = frames;
        start_frame(8'd30, 7'd40, 3'd1, 8'd60, 7'd70, 3'd2);
        wait_frame(f0);

        iEnable = 1'b0;
        f0 = frames;
        @(negedge iClock);
        iFrameTick = 1'b1;
        @(negedge iClock);
        iFrameTick = 1'b0;
        chk("enable_low_idle", oBusy, 0);
        repeat (10) @(negedge iClock);
        chk("enable_low_still_idle", oBusy, 0);
        chk("enable_low_overrun", oOverrun, 0);
        chk("enable_low_no_frame", frames, f0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
